// File: rtl/vram_port_sched_if.sv
// Bundles the CPU, fill, scan and RAM-side signals of the VRAM port scheduler.
// The slave modport is the scheduler; master is the surrounding bridge/video/RAM side.
interface vram_port_sched_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_count;
  logic [DW-1:0] fill_value;
  logic          fill_busy;
  logic          fill_done;

  logic          scan_start;
  logic [AW-1:0] scan_base;
  logic [AW:0]   scan_len;
  logic          scan_busy;
  logic          scan_valid;
  logic [DW-1:0] scan_data;

  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_data_a;
  logic          ram_we_a;
  logic [DW-1:0] ram_q_a;
  logic [AW-1:0] ram_addr_b;
  logic          ram_we_b;
  logic [DW-1:0] ram_q_b;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  fill_start, fill_base, fill_count, fill_value,
    input  scan_start, scan_base, scan_len,
    input  ram_q_a, ram_q_b,
    output cpu_ack, cpu_rvalid, cpu_rdata,
    output fill_busy, fill_done,
    output scan_busy, scan_valid, scan_data,
    output ram_addr_a, ram_data_a, ram_we_a, ram_addr_b, ram_we_b
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output fill_start, fill_base, fill_count, fill_value,
    output scan_start, scan_base, scan_len,
    output ram_q_a, ram_q_b,
    input  cpu_ack, cpu_rvalid, cpu_rdata,
    input  fill_busy, fill_done,
    input  scan_busy, scan_valid, scan_data,
    input  ram_addr_a, ram_data_a, ram_we_a, ram_addr_b, ram_we_b
  );
endinterface

// File: rtl/vram_port_sched.sv
// Dual-port VRAM sequencer: port A round-robins CPU accesses against a block-fill
// engine, port B streams a scanout run to the video pipeline.
module vram_port_sched #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input logic              clk,
  input logic              reset,
  vram_port_sched_if.slave bus
);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] MaxCnt = CW'(1) << AW;

  typedef enum logic [1:0] {FillIdle, FillRun, FillDone} fill_st_e;
  typedef enum logic       {ScanIdle, ScanRun}           scan_st_e;

  function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] c);
    return (c > MaxCnt) ? MaxCnt : c;
  endfunction

  fill_st_e      fill_st_q, fill_st_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;
  logic [CW-1:0] fill_rem_q, fill_rem_d;
  logic [DW-1:0] fill_val_q, fill_val_d;

  scan_st_e      scan_st_q, scan_st_d;
  logic [AW-1:0] scan_ptr_q, scan_ptr_d;
  logic [CW-1:0] scan_rem_q, scan_rem_d;
  logic          scan_issue_q, scan_issue_d;
  logic          scan_valid_q, scan_valid_d;
  logic [AW-1:0] addr_b_q, addr_b_d;

  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [DW-1:0] data_a_q, data_a_d;
  logic          we_a_q, we_a_d;
  logic          ack_q, ack_d;
  logic          rvalid_q, rvalid_d;
  logic          prio_fill_q, prio_fill_d;

  logic          cand_cpu, cand_fill, grant_cpu, grant_fill;
  logic [CW-1:0] fill_cnt_c, scan_len_c;

  assign fill_cnt_c = clamp_cnt(bus.fill_count);
  assign scan_len_c = clamp_cnt(bus.scan_len);

  // A held request is not re-granted while its ack is showing.
  assign cand_cpu   = bus.cpu_req & ~ack_q;
  assign cand_fill  = (fill_st_q == FillRun) && (fill_rem_q != '0);
  assign grant_cpu  = cand_cpu & (~cand_fill | ~prio_fill_q);
  assign grant_fill = cand_fill & ~grant_cpu;

  always_comb begin
    addr_a_d    = addr_a_q;
    data_a_d    = data_a_q;
    we_a_d      = 1'b0;
    ack_d       = grant_cpu;
    rvalid_d    = ack_q & ~we_a_q;
    prio_fill_d = prio_fill_q;
    if (grant_cpu) begin
      addr_a_d    = bus.cpu_addr;
      data_a_d    = bus.cpu_wdata;
      we_a_d      = bus.cpu_we;
      prio_fill_d = 1'b1;
    end else if (grant_fill) begin
      addr_a_d    = fill_ptr_q;
      data_a_d    = fill_val_q;
      we_a_d      = 1'b1;
      prio_fill_d = 1'b0;
    end
  end

  always_comb begin
    fill_st_d  = fill_st_q;
    fill_ptr_d = fill_ptr_q;
    fill_rem_d = fill_rem_q;
    fill_val_d = fill_val_q;
    unique case (fill_st_q)
      FillIdle: begin
        if (bus.fill_start) begin
          fill_ptr_d = bus.fill_base;
          fill_rem_d = fill_cnt_c;
          fill_val_d = bus.fill_value;
          fill_st_d  = (fill_cnt_c == '0) ? FillDone : FillRun;
        end
      end
      FillRun: begin
        // Leave once the final word's write cycle is on the RAM port.
        if (grant_fill) begin
          fill_ptr_d = fill_ptr_q + AW'(1);
          fill_rem_d = fill_rem_q - CW'(1);
        end else if (fill_rem_q == '0) begin
          fill_st_d = FillDone;
        end
      end
      FillDone: fill_st_d = FillIdle;
      default:  fill_st_d = FillIdle;
    endcase
  end

  always_comb begin
    scan_st_d    = scan_st_q;
    scan_ptr_d   = scan_ptr_q;
    scan_rem_d   = scan_rem_q;
    scan_issue_d = 1'b0;
    scan_valid_d = scan_issue_q;
    addr_b_d     = addr_b_q;
    if (bus.scan_start) begin
      scan_ptr_d = bus.scan_base;
      scan_rem_d = scan_len_c;
      scan_st_d  = (scan_len_c == '0) ? ScanIdle : ScanRun;
    end else if (scan_st_q == ScanRun) begin
      scan_issue_d = 1'b1;
      addr_b_d     = scan_ptr_q;
      scan_ptr_d   = scan_ptr_q + AW'(1);
      scan_rem_d   = scan_rem_q - CW'(1);
      if (scan_rem_q == CW'(1)) scan_st_d = ScanIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_st_q    <= FillIdle;
      fill_ptr_q   <= '0;
      fill_rem_q   <= '0;
      fill_val_q   <= '0;
      scan_st_q    <= ScanIdle;
      scan_ptr_q   <= '0;
      scan_rem_q   <= '0;
      scan_issue_q <= 1'b0;
      scan_valid_q <= 1'b0;
      addr_b_q     <= '0;
      addr_a_q     <= '0;
      data_a_q     <= '0;
      we_a_q       <= 1'b0;
      ack_q        <= 1'b0;
      rvalid_q     <= 1'b0;
      prio_fill_q  <= 1'b0;
    end else begin
      fill_st_q    <= fill_st_d;
      fill_ptr_q   <= fill_ptr_d;
      fill_rem_q   <= fill_rem_d;
      fill_val_q   <= fill_val_d;
      scan_st_q    <= scan_st_d;
      scan_ptr_q   <= scan_ptr_d;
      scan_rem_q   <= scan_rem_d;
      scan_issue_q <= scan_issue_d;
      scan_valid_q <= scan_valid_d;
      addr_b_q     <= addr_b_d;
      addr_a_q     <= addr_a_d;
      data_a_q     <= data_a_d;
      we_a_q       <= we_a_d;
      ack_q        <= ack_d;
      rvalid_q     <= rvalid_d;
      prio_fill_q  <= prio_fill_d;
    end
  end

  assign bus.cpu_ack    = ack_q;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_rdata  = bus.ram_q_a;
  assign bus.fill_busy  = (fill_st_q == FillRun);
  assign bus.fill_done  = (fill_st_q == FillDone);
  assign bus.scan_busy  = (scan_st_q == ScanRun);
  assign bus.scan_valid = scan_valid_q;
  assign bus.scan_data  = bus.ram_q_b;
  assign bus.ram_addr_a = addr_a_q;
  assign bus.ram_data_a = data_a_q;
  assign bus.ram_we_a   = we_a_q;
  assign bus.ram_addr_b = addr_b_q;
  assign bus.ram_we_b   = 1'b0;
endmodule
